// File: rtl/serial_adder_2b.sv
`default_nettype none
// ============================================================================
// Module   : serial_adder_2b
// Summary  : Multi-cycle WIDTH-bit adder (a + b + cin) that consumes two bits
//            per clock through a single 2-bit full adder. The carry is
//            registered between digits. The result is presented as a
//            registered sum/cout pair with a start/busy/done handshake.
// Revision : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
// twoBitAdder: combinational 2-bit full adder used as the per-digit datapath.
// ----------------------------------------------------------------------------
module twoBitAdder (
  input  logic [1:0] a,
  input  logic [1:0] b,
  input  logic       cin,
  output logic [1:0] s,
  output logic       cout
);

  // Three-bit sum of two 2-bit digits and a carry.
  assign {cout, s} = {1'b0, a} + {1'b0, b} + {2'b00, cin};

endmodule

// ----------------------------------------------------------------------------
// serial_adder_2b: digit-serial word adder around one twoBitAdder.
// ----------------------------------------------------------------------------
module serial_adder_2b #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int N  = WIDTH / 2;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             accept;
  logic             last_step;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_nxt;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic [1:0]       dig_s;
  logic             dig_c;

  // Single digit adder: low digit of each shifted operand plus stored carry.
  twoBitAdder u_digit_add (
    .a    (a_sh[1:0]),
    .b    (b_sh[1:0]),
    .cin  (carry),
    .s    (dig_s),
    .cout (dig_c)
  );

  // New digit enters the accumulator at the MSB end; for a single-digit word
  // the accumulator is just that digit.
  generate
    if (WIDTH > 2) begin : g_acc_wide
      assign acc_nxt = {dig_s, acc[WIDTH-1:2]};
    end else begin : g_acc_narrow
      assign acc_nxt = dig_s;
    end
  endgenerate

  assign last_step = (cnt == LAST_CNT);

  // Status outputs are decoded straight from the registered state.
  assign busy = (state == RUN);
  assign done = (state == DONE);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; start is only honoured while idle or reporting done.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (last_step) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Operand capture, per-digit shift/accumulate, and result update on the
  // final digit; sum/cout hold their value at all other times.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh  <= '0;
      b_sh  <= '0;
      acc   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else if (accept) begin
      a_sh  <= a;
      b_sh  <= b;
      carry <= cin;
      acc   <= '0;
      cnt   <= '0;
    end else if (state == RUN) begin
      a_sh  <= a_sh >> 2;
      b_sh  <= b_sh >> 2;
      carry <= dig_c;
      acc   <= acc_nxt;
      cnt   <= cnt + CW'(1);
      if (last_step) begin
        sum  <= acc_nxt;
        cout <= dig_c;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_serial_adder_2b.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_adder_2b
// Summary  : Self-checking bench for serial_adder_2b (WIDTH=8 and WIDTH=2)
//            against a plain-arithmetic reference of a + b + cin.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_adder_2b;

  logic       clk;
  logic       rst_n;

  logic       start8;
  logic [7:0] a8;
  logic [7:0] b8;
  logic       cin8;
  logic       busy8;
  logic       done8;
  logic [7:0] sum8;
  logic       cout8;

  logic       start2;
  logic [1:0] a2;
  logic [1:0] b2;
  logic       cin2;
  logic       busy2;
  logic       done2;
  logic [1:0] sum2;
  logic       cout2;

  int n_checks;
  int n_pass;

  serial_adder_2b #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start8),
    .a     (a8),
    .b     (b8),
    .cin   (cin8),
    .busy  (busy8),
    .done  (done8),
    .sum   (sum8),
    .cout  (cout8)
  );

  serial_adder_2b #(.WIDTH(2)) dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start2),
    .a     (a2),
    .b     (b2),
    .cin   (cin2),
    .busy  (busy2),
    .done  (done2),
    .sum   (sum2),
    .cout  (cout2)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: full-precision arithmetic, {cout,sum} = a + b + cin.
  function automatic logic [8:0] ref8(input logic [7:0] x, input logic [7:0] y, input logic c);
    return 9'(x) + 9'(y) + 9'(c);
  endfunction

  // One WIDTH=8 operation. Inputs change at negedges; outputs are sampled at
  // negedges. With noisy=1, start and operands are scrambled during RUN.
  task automatic op8(input logic [7:0] x, input logic [7:0] y, input logic c, input bit noisy);
    logic [8:0] exp;
    int         cyc;
    int         busy_cnt;
    exp = ref8(x, y, c);
    @(negedge clk);
    start8 = 1'b1; a8 = x; b8 = y; cin8 = c;
    @(negedge clk);
    start8 = 1'b0;
    cyc = 0;
    busy_cnt = 0;
    while (!done8 && cyc < 20) begin
      if (busy8) busy_cnt++;
      if (noisy) begin
        start8 = 1'b1; a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
      end else begin
        a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
      end
      @(negedge clk);
      cyc++;
    end
    start8 = 1'b0;
    check("latency8", 64'(cyc), 64'd4);
    check("busy_cycles8", 64'(busy_cnt), 64'd4);
    check("sum8", 64'(sum8), 64'(exp[7:0]));
    check("cout8", 64'(cout8), 64'(exp[8]));
    @(negedge clk);
    check("done_pulse8", 64'(done8), 64'd0);
    check("busy_idle8", 64'(busy8), 64'd0);
    check("sum_hold8", 64'({cout8, sum8}), 64'(exp));
  endtask

  initial begin
    logic [8:0] e1;
    logic [8:0] e2;
    logic [2:0] e3;
    int cyc;
    int gap;
    int dones;
    n_checks = 0;
    n_pass   = 0;
    rst_n  = 1'b0;
    start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    start2 = 1'b0; a2 = '0; b2 = '0; cin2 = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", 64'(busy8), 64'd0);
    check("rst_done", 64'(done8), 64'd0);
    check("rst_sum", 64'(sum8), 64'd0);
    check("rst_cout", 64'(cout8), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_busy", 64'(busy8), 64'd0);

    // Directed cases.
    op8(8'h5A, 8'h3C, 1'b0, 1'b0);
    op8(8'hFF, 8'h01, 1'b0, 1'b0);
    op8(8'hFF, 8'hFF, 1'b1, 1'b0);
    // Start and operands pulsed every RUN cycle must be ignored.
    op8(8'h12, 8'h34, 1'b1, 1'b1);

    // Start held high: two operations back to back, done pulses N+1 apart.
    e1 = ref8(8'h01, 8'h01, 1'b0);
    e2 = ref8(8'h80, 8'h80, 1'b0);
    @(negedge clk);
    start8 = 1'b1; a8 = 8'h01; b8 = 8'h01; cin8 = 1'b0;
    @(negedge clk);
    a8 = 8'h80; b8 = 8'h80; cin8 = 1'b0;
    cyc = 0;
    while (!done8 && cyc < 20) begin @(negedge clk); cyc++; end
    check("b2b_lat1", 64'(cyc), 64'd4);
    check("b2b_res1", 64'({cout8, sum8}), 64'(e1));
    gap = 0;
    @(negedge clk); gap++;
    check("b2b_nostretch", 64'(done8), 64'd0);
    while (!done8 && gap < 20) begin @(negedge clk); gap++; end
    start8 = 1'b0;
    check("b2b_gap", 64'(gap), 64'd5);
    check("b2b_res2", 64'({cout8, sum8}), 64'(e2));
    @(negedge clk);
    check("b2b_end", 64'(done8), 64'd0);

    // Reset in mid-RUN discards the operation.
    @(negedge clk);
    start8 = 1'b1; a8 = 8'h7F; b8 = 8'h01; cin8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 64'(busy8), 64'd0);
    check("mid_rst_sum", 64'(sum8), 64'd0);
    check("mid_rst_cout", 64'(cout8), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done8 || busy8) dones++;
    end
    check("mid_rst_no_done", 64'(dones), 64'd0);
    op8(8'h10, 8'h20, 1'b0, 1'b0);

    // Randomized operations against the arithmetic reference.
    for (int i = 0; i < 20; i++) begin
      op8(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
    end

    // WIDTH=2, exhaustive: done one cycle after each start.
    for (int v = 0; v < 32; v++) begin
      logic [4:0] vv;
      vv = 5'(v);
      e3 = 3'(vv[4:3]) + 3'(vv[2:1]) + 3'(vv[0]);
      @(negedge clk);
      start2 = 1'b1; a2 = vv[4:3]; b2 = vv[2:1]; cin2 = vv[0];
      @(negedge clk);
      start2 = 1'b0; a2 = 2'($urandom); b2 = 2'($urandom); cin2 = 1'($urandom);
      cyc = 0;
      while (!done2 && cyc < 10) begin @(negedge clk); cyc++; end
      check("w2_latency", 64'(cyc), 64'd1);
      check("w2_result", 64'({cout2, sum2}), 64'(e3));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
